// File: rtl/mhp_task_scheduler.sv
// mhp_task_scheduler: queues task numbers and serialises them onto one MHP engine
// with opcode mapping, reply matching, timeout and bounded retry.
module mhp_task_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_task_valid,
    input  logic [15:0]                   i_task_nbr,
    output logic                          o_task_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_busy,
    output logic                          o_send,
    output logic                          o_enable,
    output logic [7:0]                    o_dtype,
    input  logic                          i_done,
    input  logic [6:0]                    i_rx_dtype,
    input  logic [15:0]                   i_rx_dst,
    input  logic [15:0]                   i_rx_src,
    output logic [15:0]                   o_dest_addr,
    output logic [15:0]                   o_src_addr,
    output logic                          o_grant_strobe,
    output logic                          o_err_strobe,
    output logic [15:0]                   o_err_task
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TX, WAIT_RX, GRANT, ERR} state_t;

    state_t         state_q, state_d;
    logic [15:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  level_q;
    logic [15:0]    task_q, dest_q, src_q, err_task_q;
    logic [RW-1:0]  retry_q, retry_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     dtype_q;
    logic           send_q, push, pop, timeout, can_retry, match;

    // Bit 7 doubles as the "supported" flag; unsupported tasks map to 0x00.
    function automatic logic [7:0] map_op(input logic [7:0] t);
        return t == 8'h10 ? 8'h83 : t == 8'h20 ? 8'h81 : t == 8'h30 ? 8'h85 : 8'h00;
    endfunction

    assign o_task_ready   = level_q < LW'(FIFO_DEPTH);
    assign push           = i_task_valid && o_task_ready;
    assign pop            = state_q == IDLE && level_q != '0;
    // The timer reaches TIMEOUT_CYCLES-1 on the step taken from TIMEOUT_CYCLES-2.
    assign timeout        = timer_q == TW'(TIMEOUT_CYCLES - 2);
    assign can_retry      = retry_q < RW'(MAX_RETRY);
    assign match          = i_done && i_rx_dtype == dtype_q[6:0];
    assign o_fifo_level   = level_q;
    assign o_busy         = state_q != IDLE;
    assign o_enable       = state_q == ISSUE || state_q == WAIT_TX || state_q == WAIT_RX;
    assign o_grant_strobe = state_q == GRANT;
    assign o_err_strobe   = state_q == ERR;
    assign o_send         = send_q;
    assign o_dtype        = dtype_q;
    assign o_dest_addr    = dest_q;
    assign o_src_addr     = src_q;
    assign o_err_task     = err_task_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                state_d = pop ? ISSUE : IDLE;
                retry_d = pop ? '0 : retry_q;
            end
            ISSUE: begin
                state_d = dtype_q[7] ? WAIT_TX : ERR;
                timer_d = '0;
            end
            WAIT_TX, WAIT_RX: begin
                if (state_q == WAIT_TX ? i_done : match) begin
                    state_d = state_q == WAIT_TX ? WAIT_RX : GRANT;
                    timer_d = '0;
                end else if (timeout) begin
                    state_d = can_retry ? ISSUE : ERR;
                    retry_d = can_retry ? retry_q + RW'(1) : retry_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_task_nbr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            task_q     <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            send_q     <= 1'b0;
            dtype_q    <= '0;
            dest_q     <= '0;
            src_q      <= '0;
            err_task_q <= '0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            wr_ptr_q   <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            level_q    <= level_q + LW'(push) - LW'(pop);
            task_q     <= pop ? mem_q[rd_ptr_q] : task_q;
            dtype_q    <= pop ? map_op(mem_q[rd_ptr_q][7:0]) : dtype_q;
            send_q     <= state_q == ISSUE && dtype_q[7];
            dest_q     <= state_d == GRANT && state_q != GRANT ? i_rx_dst : dest_q;
            src_q      <= state_d == GRANT && state_q != GRANT ? i_rx_src : src_q;
            err_task_q <= state_d == ERR && state_q != ERR ? task_q : err_task_q;
        end
    end
endmodule
